// File: rtl/csi2_pkg.sv
// CSI-2 data-type codes and the packet sequencer state set shared by the D-PHY
// packet sequencer and the protocol layers above it.
package csi2_pkg;

  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_LINE_START  = 6'h02;
  localparam logic [5:0] DT_LINE_END    = 6'h03;
  localparam logic [5:0] DT_RAW8        = 6'h2A;
  localparam logic [5:0] DT_RAW10       = 6'h2B;

  localparam logic [5:0] SHORT_PACKET_MAX = 6'h0F;

  typedef enum logic [2:0] {
    RESET_PHY,
    WAIT_SYNC,
    HEADER,
    PAYLOAD,
    CRC
  } seq_state_e;

  function automatic logic is_short_packet(input logic [5:0] data_type);
    return data_type <= SHORT_PACKET_MAX;
  endfunction

endpackage

// File: rtl/d_phy_packet_sequencer_if.sv
// Byte stream from d_phy_receiver plus the delimited packet fields handed upward.
// No backpressure: the slave side must take every strobe.
interface d_phy_packet_sequencer_if;

  logic        capture_enable;
  logic [7:0]  phy_data;
  logic        phy_enable;
  logic        phy_reset;
  logic        header_valid;
  logic [7:0]  data_id;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        payload_last;
  logic [15:0] crc;
  logic        crc_valid;
  logic        error;
  logic        busy;

  modport master (
    input  capture_enable, phy_data, phy_enable,
    output phy_reset, header_valid, data_id, word_count, ecc,
           payload_data, payload_valid, payload_last, crc, crc_valid, error, busy
  );

  modport slave (
    output capture_enable, phy_data, phy_enable,
    input  phy_reset, header_valid, data_id, word_count, ecc,
           payload_data, payload_valid, payload_last, crc, crc_valid, error, busy
  );

endinterface

// File: rtl/d_phy_packet_sequencer.sv
// Delimits CSI-2 packets from the receiver byte stream and pulses the receiver reset between them.
// All outputs registered, one cycle after the causing byte; no backpressure.
module d_phy_packet_sequencer
  import csi2_pkg::*;
#(
  parameter int          RESET_CYCLES   = 4,
  parameter logic [15:0] MAX_WORD_COUNT = 16'd8192
) (
  input  logic                      clock_p,
  input  logic                      reset,
  d_phy_packet_sequencer_if.master  bus
);

  localparam int             CW       = $clog2(RESET_CYCLES);
  localparam logic [CW-1:0]  RST_LOAD = CW'(RESET_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] rst_cnt_q, rst_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    di_q, di_d;
  logic [15:0]   wc_q, wc_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [7:0]    crc_lo_q, crc_lo_d;

  logic          phy_reset_q, phy_reset_d;
  logic          header_valid_q, header_valid_d;
  logic [7:0]    data_id_q, data_id_d;
  logic [15:0]   word_count_q, word_count_d;
  logic [7:0]    ecc_q, ecc_d;
  logic [7:0]    payload_data_q, payload_data_d;
  logic          payload_valid_q, payload_valid_d;
  logic          payload_last_q, payload_last_d;
  logic [15:0]   crc_q, crc_d;
  logic          crc_valid_q, crc_valid_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  // The receiver output is garbage while we hold it in reset, so gate on our own reset.
  logic byte_acc;
  assign byte_acc = bus.phy_enable & ~phy_reset_q;

  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    idx_d           = idx_q;
    di_d            = di_q;
    wc_d            = wc_q;
    remaining_d     = remaining_q;
    crc_lo_d        = crc_lo_q;
    header_valid_d  = 1'b0;
    payload_valid_d = 1'b0;
    payload_last_d  = 1'b0;
    crc_valid_d     = 1'b0;
    error_d         = 1'b0;
    data_id_d       = data_id_q;
    word_count_d    = word_count_q;
    ecc_d           = ecc_q;
    payload_data_d  = payload_data_q;
    crc_d           = crc_q;

    case (state_q)
      RESET_PHY: begin
        if (rst_cnt_q != '0) begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end else if (bus.capture_enable) begin
          state_d = WAIT_SYNC;
        end
      end

      WAIT_SYNC: begin
        if (byte_acc) begin
          di_d    = bus.phy_data;
          idx_d   = 2'd1;
          state_d = HEADER;
        end else if (!bus.capture_enable) begin
          state_d   = RESET_PHY;
          rst_cnt_d = RST_LOAD;
        end
      end

      HEADER: begin
        if (byte_acc) begin
          case (idx_q)
            2'd1: begin
              wc_d[7:0] = bus.phy_data;
              idx_d     = 2'd2;
            end
            2'd2: begin
              wc_d[15:8] = bus.phy_data;
              idx_d      = 2'd3;
            end
            default: begin
              // Oversized long packets are dropped without announcing a header.
              if (!is_short_packet(di_q[5:0]) && (wc_q > MAX_WORD_COUNT)) begin
                error_d   = 1'b1;
                state_d   = RESET_PHY;
                rst_cnt_d = RST_LOAD;
              end else begin
                header_valid_d = 1'b1;
                data_id_d      = di_q;
                word_count_d   = wc_q;
                ecc_d          = bus.phy_data;
                if (is_short_packet(di_q[5:0])) begin
                  state_d   = RESET_PHY;
                  rst_cnt_d = RST_LOAD;
                end else if (wc_q == 16'd0) begin
                  state_d = CRC;
                  idx_d   = 2'd0;
                end else begin
                  remaining_d = wc_q;
                  state_d     = PAYLOAD;
                end
              end
            end
          endcase
        end
      end

      PAYLOAD: begin
        if (byte_acc) begin
          payload_data_d  = bus.phy_data;
          payload_valid_d = 1'b1;
          payload_last_d  = (remaining_q == 16'd1);
          remaining_d     = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = CRC;
            idx_d   = 2'd0;
          end
        end
      end

      CRC: begin
        if (byte_acc) begin
          if (idx_q == 2'd0) begin
            crc_lo_d = bus.phy_data;
            idx_d    = 2'd1;
          end else begin
            crc_d       = {bus.phy_data, crc_lo_q};
            crc_valid_d = 1'b1;
            state_d     = RESET_PHY;
            rst_cnt_d   = RST_LOAD;
          end
        end
      end

      default: begin
        state_d   = RESET_PHY;
        rst_cnt_d = RST_LOAD;
      end
    endcase

    phy_reset_d = (state_d == RESET_PHY);
    busy_d      = (state_d == HEADER) || (state_d == PAYLOAD) || (state_d == CRC);
  end

  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      state_q         <= RESET_PHY;
      rst_cnt_q       <= RST_LOAD;
      idx_q           <= 2'd0;
      di_q            <= 8'd0;
      wc_q            <= 16'd0;
      remaining_q     <= 16'd0;
      crc_lo_q        <= 8'd0;
      phy_reset_q     <= 1'b1;
      header_valid_q  <= 1'b0;
      data_id_q       <= 8'd0;
      word_count_q    <= 16'd0;
      ecc_q           <= 8'd0;
      payload_data_q  <= 8'd0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      crc_q           <= 16'd0;
      crc_valid_q     <= 1'b0;
      error_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      idx_q           <= idx_d;
      di_q            <= di_d;
      wc_q            <= wc_d;
      remaining_q     <= remaining_d;
      crc_lo_q        <= crc_lo_d;
      phy_reset_q     <= phy_reset_d;
      header_valid_q  <= header_valid_d;
      data_id_q       <= data_id_d;
      word_count_q    <= word_count_d;
      ecc_q           <= ecc_d;
      payload_data_q  <= payload_data_d;
      payload_valid_q <= payload_valid_d;
      payload_last_q  <= payload_last_d;
      crc_q           <= crc_d;
      crc_valid_q     <= crc_valid_d;
      error_q         <= error_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.phy_reset     = phy_reset_q;
  assign bus.header_valid  = header_valid_q;
  assign bus.data_id       = data_id_q;
  assign bus.word_count    = word_count_q;
  assign bus.ecc           = ecc_q;
  assign bus.payload_data  = payload_data_q;
  assign bus.payload_valid = payload_valid_q;
  assign bus.payload_last  = payload_last_q;
  assign bus.crc           = crc_q;
  assign bus.crc_valid     = crc_valid_q;
  assign bus.error         = error_q;
  assign bus.busy          = busy_q;

endmodule
